// File: rtl/or_gate.sv
// ============================================================================
// Module   : or_gate
// Brief    : Bitwise OR with a combinational result, a registered copy with
//            valid flag, and an optional saturating hit counter
//            (enabled by defining OR_GATE_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_gate #(
  parameter int WIDTH = 1,   // 1..64
  parameter int CNT_W = 16   // 4..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid,
  output logic             any_q
`ifdef OR_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 4 || CNT_W > 32) begin : g_bad_param
    $error("or_gate: WIDTH or CNT_W out of range");
  end

  logic [WIDTH-1:0] w_or;
  logic             w_any;
  logic [WIDTH-1:0] r_c_q;
  logic             r_out_valid;
  logic             r_any_q;

  assign w_or  = A | B;
  assign w_any = |w_or;
  assign C     = w_or;

  // Result registers hold when idle; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_q       <= '0;
      r_out_valid <= 1'b0;
      r_any_q     <= 1'b0;
    end else if (in_valid) begin
      r_c_q       <= w_or;
      r_out_valid <= 1'b1;
      r_any_q     <= w_any;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign C_q       = r_c_q;
  assign out_valid = r_out_valid;
  assign any_q     = r_any_q;

`ifdef OR_GATE_STATS_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_hit_cnt;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (in_valid && w_any && (r_hit_cnt != {CNT_W{1'b1}})) begin
      r_hit_cnt <= r_hit_cnt + c_cnt_one;
    end
  end

  assign hit_cnt = r_hit_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_or_gate.sv
// Testbench for or_gate: vector table, directed corner sequences and random
// stimulus against a spec-level reference model.
`default_nettype none

module tb_or_gate;

  localparam int W      = 4;
  localparam int CW     = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic          in_valid;
  logic [W-1:0]  c, c_q;
  logic          out_valid, any_q;
  logic [CW-1:0] hit_cnt;

  logic a1, b1, c1, c_q1, ov1, any1;
`ifdef OR_GATE_STATS_EN
  logic [15:0] hit_cnt1;
`endif

  always #5 clk = ~clk;

  or_gate #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid),
    .C(c), .C_q(c_q), .out_valid(out_valid), .any_q(any_q)
`ifdef OR_GATE_STATS_EN
    , .hit_cnt(hit_cnt)
`endif
  );

`ifndef OR_GATE_STATS_EN
  assign hit_cnt = '0;
`endif

  or_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(1'b1), .A(a1), .B(b1), .in_valid(1'b0),
    .C(c1), .C_q(c_q1), .out_valid(ov1), .any_q(any1)
`ifdef OR_GATE_STATS_EN
    , .hit_cnt(hit_cnt1)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference state, derived from the behavioural rules
  int m_cq, m_any, m_ov, m_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge; model consumes the inputs present at that edge.
  task automatic tick();
    int r;
    @(posedge clk);
    r = int'(a) | int'(b);
    if (!rst_n) begin
      m_cq = 0; m_any = 0; m_ov = 0; m_cnt = 0;
    end else if (in_valid) begin
      m_cq  = r;
      m_any = (r != 0) ? 1 : 0;
      m_ov  = 1;
      if (r != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic drive(input logic rn, input logic v, input logic [W-1:0] va,
                       input logic [W-1:0] vb);
    rst_n = rn; in_valid = v; a = va; b = vb;
  endtask

  typedef struct {
    logic         rn;
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_c;
    logic [W-1:0] exp_cq;
    logic         exp_any;
    logic         exp_ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h5, 4'h2, 4'h7, 4'h7, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h7, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 4'h9, 4'h6, 4'hF, 4'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'h8, 4'h1, 4'h9, 4'h9, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 4'h3, 4'hC, 4'hF, 4'hF, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 4'h0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1};

    m_cq = 0; m_any = 0; m_ov = 0; m_cnt = 0;
    drive(1'b0, 1'b0, '0, '0);
    a1 = 1'b0; b1 = 1'b0;

    // WIDTH=1 truth table, no clock involvement
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = i[1:0];
      a1 = ab[1]; b1 = ab[0];
      #10;
      chk("truth_table_C", c1, (i != 0) ? 1 : 0);
    end

    tick(); tick();
    chk("reset_C_q", c_q, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_any_q", any_q, 0);
`ifdef OR_GATE_STATS_EN
    chk("reset_hit_cnt", hit_cnt, 0);
`endif

    // Vector table: combinational C before the edge, registered after
    for (int i = 0; i < 9; i++) begin
      int cnt_before;
      drive(vecs[i].rn, vecs[i].v, vecs[i].a, vecs[i].b);
      #1;
      chk("vec_C", c, vecs[i].exp_c);
      cnt_before = m_cnt;
      tick();
      chk("vec_C_q", c_q, vecs[i].exp_cq);
      chk("vec_any_q", any_q, vecs[i].exp_any);
      chk("vec_out_valid", out_valid, vecs[i].exp_ov);
`ifdef OR_GATE_STATS_EN
      chk("vec_hit_cnt", hit_cnt, m_cnt);
      if (i == 3) chk("zero_result_cnt_unchanged", hit_cnt, cnt_before);
`endif
    end

    // Streaming: back-to-back valid samples, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, W'(i), '0);
      tick();
      chk("stream_out_valid", out_valid, 1);
      chk("stream_C_q", c_q, i);
    end
    drive(1'b1, 1'b0, 4'hA, 4'h0);
    tick();
    chk("stream_end_out_valid", out_valid, 0);
    chk("stream_hold_C_q", c_q, 7);

    // Counter saturation: 20 nonzero samples
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, W'((i % 15) + 1), '0);
      tick();
    end
`ifdef OR_GATE_STATS_EN
    chk("sat_hit_cnt", hit_cnt, CNT_MAX);
`endif
    chk("sat_C_q", c_q, (19 % 15) + 1);
    drive(1'b0, 1'b1, 4'hF, 4'hF);
    tick();
    chk("sat_reset_out_valid", out_valid, 0);
`ifdef OR_GATE_STATS_EN
    chk("sat_reset_hit_cnt", hit_cnt, 0);
`endif

    // Random stimulus against the reference model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1,
            W'($urandom), W'($urandom));
      #1;
      chk("rand_C", c, int'(a) | int'(b));
      tick();
      chk("rand_C_q", c_q, m_cq);
      chk("rand_any_q", any_q, m_any);
      chk("rand_out_valid", out_valid, m_ov);
`ifdef OR_GATE_STATS_EN
      chk("rand_hit_cnt", hit_cnt, m_cnt);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
